ref_win_sample_buf: RTL and testbench

- Sits directly downstream of the reference-window write-enable FSM.
- Captures one pixel per `wr` strobe, i.e. one sample per window column: 80 samples per window row at 640/8.
- Stores the samples into a ping-pong pair of row banks.
- Drains each completed bank over a valid/ready stream to the watermark correlation stage, so filling of the next window row overlaps draining.

---
 rtl/ref_win_sample_buf.sv | 127 ++++++++++++
 tb/tb_ref_win_sample_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ref_win_sample_buf.sv
// Ping-pong row buffer between the reference-window write FSM and the watermark
// correlator: one sample per window column is captured, and completed rows drain over valid/ready.
module ref_win_sample_buf #(
  parameter int width  = 640,
  parameter int w_size = 8,
  parameter int DATA_W = 8,
  parameter int N_SAMP = width / w_size,
  parameter int IDX_W  = 7
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              sof,
  input  logic              wr,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [1:0]        bank_full,
  output logic              ovf,
  input  logic              clr_ovf
);

  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMP - 1);

  logic [DATA_W-1:0] mem [2][N_SAMP];

  rstate_t          rstate;
  logic             wbank, rbank;
  logic [IDX_W-1:0] wptr, raddr, waddr;
  logic             rd_release, wr_free, do_write, do_drop, wr_last;
  logic [1:0]       bank_full_nxt;

  // A bank finishing its last handshake is free to the writer in the same cycle.
  always_comb begin
    rd_release = (rstate == R_SEND) && out_valid && out_ready && out_last;
    wr_free    = !bank_full[wbank] || (rd_release && (rbank == wbank));
    do_write   = wr && wr_free;
    do_drop    = wr && !wr_free;
    waddr      = sof ? '0 : wptr;
    wr_last    = (waddr == LAST_IDX);
  end

  always_comb begin
    bank_full_nxt = bank_full;
    if (rd_release)
      bank_full_nxt[rbank] = 1'b0;
    if (do_write && wr_last)
      bank_full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (do_write)
      mem[wbank][waddr] <= pix_in;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wbank     <= 1'b0;
      wptr      <= '0;
      bank_full <= 2'b00;
      ovf       <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (do_write) begin
        if (wr_last) begin
          wptr  <= '0;
          wbank <= ~wbank;
        end else begin
          wptr <= waddr + 1'b1;
        end
      end else if (sof) begin
        wptr <= '0;
      end
      // A drop in the same cycle as a clear must still be reported.
      if (do_drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rstate    <= R_IDLE;
      rbank     <= 1'b0;
      raddr     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (bank_full[rbank]) begin
            raddr  <= '0;
            rstate <= R_LOAD;
          end
        end
        R_LOAD: begin
          out_valid <= 1'b1;
          out_data  <= mem[rbank][raddr];
          out_idx   <= raddr;
          out_last  <= (raddr == LAST_IDX);
          rstate    <= R_SEND;
        end
        R_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              rbank  <= ~rbank;
              rstate <= R_IDLE;
            end else begin
              raddr  <= raddr + 1'b1;
              rstate <= R_LOAD;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_win_sample_buf.sv
// Self-checking bench for ref_win_sample_buf: directed scenarios plus a randomized
// phase, all checked against a row-FIFO reference model of the buffer.
module tb_ref_win_sample_buf;

  localparam int N = 80;

  logic       pclk = 1'b0;
  logic       rst, sof, wr, out_ready, clr_ovf;
  logic [7:0] pix_in;
  logic       out_valid, out_last, ovf;
  logic [7:0] out_data;
  logic [6:0] out_idx;
  logic [1:0] bank_full;

  ref_win_sample_buf dut (
    .pclk(pclk), .rst(rst), .sof(sof), .wr(wr), .pix_in(pix_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .bank_full(bank_full),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;

  // Reference model: rows queued for output in order, the row being filled,
  // per-bank occupancy and the sticky overflow flag.
  byte unsigned exp_q[$];
  byte unsigned cur_row[$];
  bit [1:0] mfull;
  bit       wb, rb;
  int       rd_idx;
  bit       movf;
  bit       rdy_lvl;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_row.delete();
    mfull  = 2'b00;
    wb     = 1'b0;
    rb     = 1'b0;
    rd_idx = 0;
    movf   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the visible outputs, advance the model, step the clock.
  task automatic applyStimulus(input bit w, input byte unsigned p, input bit s, input bit rdy, input bit clr);
    bit rel;
    bit wfree;
    rel   = 1'b0;
    wfree = 1'b1;
    wr = w; pix_in = p; sof = s; out_ready = rdy; clr_ovf = clr;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
        checkOutput("out_idx", 32'(out_idx), 32'(rd_idx));
        checkOutput("out_last", 32'(out_last), 32'(rd_idx == N - 1));
        if (rdy) begin
          void'(exp_q.pop_front());
          rel    = (rd_idx == N - 1);
          rd_idx = rel ? 0 : rd_idx + 1;
        end
      end
    end
    if (s)
      cur_row.delete();
    if (w)
      wfree = !mfull[wb] || (rel && (rb == wb));
    if (rel) begin
      mfull[rb] = 1'b0;
      rb = !rb;
    end
    if (w && wfree) begin
      cur_row.push_back(p);
      if (cur_row.size() == N) begin
        foreach (cur_row[i]) exp_q.push_back(cur_row[i]);
        cur_row.delete();
        mfull[wb] = 1'b1;
        wb = !wb;
      end
    end
    if (w && !wfree)
      movf = 1'b1;
    else if (clr)
      movf = 1'b0;
    @(posedge pclk);
    #1;
    checkOutput("ovf", 32'(ovf), 32'(movf));
    checkOutput("bank_full", 32'(bank_full), 32'(mfull));
  endtask

  task automatic write_pix(input byte unsigned v, input bit s, input int gap);
    applyStimulus(1'b1, v, s, rdy_lvl, 1'b0);
    repeat (gap) applyStimulus(1'b0, 8'd0, 1'b0, rdy_lvl, 1'b0);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0 || bank_full !== 2'b00) && c < 3000) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      c++;
    end
    checkOutput("drain_timeout", 32'(c < 3000), 32'd1);
  endtask

  task automatic do_reset();
    wr = 1'b0; sof = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge pclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; wr = 1'b0; sof = 1'b0; pix_in = 8'd0; out_ready = 1'b0; clr_ovf = 1'b0;
    rdy_lvl = 1'b1;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_full", 32'(bank_full), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    $display("[TB] sequential fill");
    for (int k = 0; k < N - 1; k++) write_pix(8'(k), 1'b0, 7);
    applyStimulus(1'b1, 8'(N - 1), 1'b0, 1'b1, 1'b0);
    checkOutput("fill_full", 32'(bank_full), 32'd1);
    checkOutput("lat0", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat1", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat2", 32'(out_valid), 32'd1);
    drain();

    $display("[TB] ping-pong");
    do_reset();
    for (int k = 0; k < 2 * N; k++) write_pix(8'(k), 1'b0, 7);
    drain();

    $display("[TB] back-pressure and overflow");
    rdy_lvl = 1'b0;
    for (int k = 0; k <= 2 * N; k++) write_pix(8'(k), 1'b0, 7);
    checkOutput("bp_full", 32'(bank_full), 32'd3);
    checkOutput("bp_ovf", 32'(ovf), 32'd1);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_data", 32'(out_data), 32'd0);
    checkOutput("bp_idx", 32'(out_idx), 32'd0);
    repeat (4) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(ovf), 32'd0);

    $display("[TB] release and write in the same cycle");
    c = 0;
    while (!(out_valid === 1'b1 && rd_idx == N - 1) && c < 400) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      c++;
    end
    checkOutput("rel_wait_timeout", 32'(c < 400), 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    checkOutput("rel_ovf", 32'(ovf), 32'd0);
    rdy_lvl = 1'b1;
    for (int k = 0; k < N - 1; k++) write_pix(8'($urandom), 1'b0, 7);
    drain();

    $display("[TB] sof mid-row");
    for (int k = 1; k <= 30; k++) write_pix(8'(k), 1'b0, 7);
    write_pix(8'h55, 1'b1, 7);
    for (int k = 0; k < N - 1; k++) write_pix(8'(100 + k), 1'b0, 7);
    drain();

    $display("[TB] async reset mid-stream");
    rdy_lvl = 1'b0;
    for (int k = 0; k < N; k++) write_pix(8'($urandom), 1'b0, 7);
    c = 0;
    while (!(out_valid === 1'b1 && rd_idx == 40) && c < 400) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      c++;
    end
    checkOutput("rst_wait_timeout", 32'(c < 400), 32'd1);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_full", 32'(bank_full), 32'd0);
    checkOutput("arst_ovf", 32'(ovf), 32'd0);
    checkOutput("arst_idx", 32'(out_idx), 32'd0);
    model_reset();
    @(posedge pclk);
    #1;
    rst = 1'b0;
    rdy_lvl = 1'b1;
    for (int k = 0; k < N; k++) write_pix(8'(200 + k), 1'b0, 7);
    drain();

    $display("[TB] randomized traffic");
    repeat (400) begin
      rdy_lvl = ($urandom_range(0, 3) != 0);
      write_pix(8'($urandom), ($urandom_range(0, 39) == 0), $urandom_range(7, 10));
      if ($urandom_range(0, 15) == 0)
        applyStimulus(1'b0, 8'd0, 1'b0, rdy_lvl, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
